llbit_ctrl: RTL
===============

LLBIT_CTRL -- requirements
Module: llbit_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock; rising edge active.
REQ-002 SHALL have port rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have port ll_commit  in  1  LL.W retires this cycle.
REQ-004 SHALL have port ll_addr  in  32  physical address of the retiring LL.W.
REQ-005 SHALL have port sc_req_valid  in  1  SC.W requests a success decision.
REQ-006 SHALL have port sc_req_ready  out  1  the controller accepts the SC request.
REQ-007 SHALL have port sc_addr  in  32  SC.W address.
REQ-008 SHALL have port sc_resp_valid  out  1  SC result available.
REQ-009 SHALL have port sc_resp_ok  out  1  SC result: 1 = store performs, rd <= 1.
REQ-010 SHALL have port sc_resp_ready  in  1  the consumer takes the SC result.
REQ-011 SHALL have port ertn  in  1  ERTN retires this cycle.
REQ-012 SHALL have port flush  in  1  pipeline flush; cancels any in-flight SC.
REQ-013 SHALL have port llbctl_we  in  1  CSR write to LLBCTL (0x060).
REQ-014 SHALL have port llbctl_wdata  in  32  CSR write data; bit1 = WCLLB, bit2 = KLO.
REQ-015 SHALL have port llbctl_rdata  out  32  the value {29'b0, KLO, 1'b0, ROLLB}.
REQ-016 SHALL have port llbit  out  1  current LLBit (ROLLB).

Function
REQ-017 SHALL implement a 3-state FSM: IDLE (llbit=0), HELD (llbit=1), SC_PEND (response outstanding).
REQ-018 SHALL drive sc_req_ready=1 in IDLE and HELD, and 0 in SC_PEND.
REQ-019 On accepting an SC request (valid&&ready), SHALL register ok = llbit [&& address match, see REQ-033], enter SC_PEND, and raise sc_resp_valid the next cycle (latency 1).
REQ-020 SHALL hold sc_resp_valid and sc_resp_ok stable until sc_resp_ready=1.
REQ-021 On the response handshake, SHALL clear llbit and go to IDLE, whatever the value of ok.
REQ-022 ll_commit SHALL set llbit and enter HELD from IDLE or HELD; it SHALL be ignored in SC_PEND.
REQ-023 ertn with KLO=1 SHALL clear KLO and keep llbit; ertn with KLO=0 SHALL clear llbit (HELD -> IDLE).
REQ-024 llbctl_we with WCLLB=1 SHALL clear llbit; llbctl_we SHALL load KLO from wdata bit2; WCLLB SHALL read back as 0.
REQ-025 flush SHALL drop an SC_PEND response (sc_resp_valid=0 the next cycle) and return the FSM to HELD if llbit=1, else to IDLE; llbit SHALL be unchanged.
REQ-026 Simultaneous events SHALL follow the priority flush > ertn > CSR write > SC handshake > ll_commit; a lower-priority event SHALL be applied after a higher one only where the two do not conflict.
REQ-027 ll_commit and a clear on the same cycle SHALL result in the clear winning (llbit=0).
REQ-028 sc_req_valid together with flush in the same cycle SHALL NOT be accepted.
REQ-029 llbctl_rdata and llbit SHALL be combinational views of the registers, with no added latency.

Reset
REQ-030 On rst_n=0, SHALL set the FSM to IDLE, llbit=0, KLO=0, sc_resp_valid=0, sc_resp_ok=0 and the stored address to 0; sc_req_ready SHALL be 1.
REQ-031 Reset asserted in SC_PEND SHALL discard the pending response immediately (asynchronously).

Configuration
REQ-032 The macro LLSC_ADDR_CHECK_EN SHALL select address tracking.
REQ-033 With LLSC_ADDR_CHECK_EN defined, ll_commit SHALL store ll_addr[31:2], and SC ok SHALL require llbit && sc_addr[31:2]==stored.
REQ-034 Without LLSC_ADDR_CHECK_EN, no address register SHALL exist, sc_addr SHALL be ignored, and ok SHALL equal llbit.

Verification
REQ-035 Scenario: reset; LL at 0x1000; SC at 0x1000 with resp_ready=1 -> resp_valid 1 cycle later, ok=1, llbit=0 afterwards.
REQ-036 Scenario: SC with no prior LL -> ok=0; then hold resp_ready=0 for 3 cycles -> resp_valid and ok stable, sc_req_ready=0 throughout.
REQ-037 Scenario: LL; CSR write 0x4 (KLO); ertn -> llbit=1, rdata=0x1; second ertn -> llbit=0, rdata=0x0.
REQ-038 Scenario: LL; SC accepted; flush the next cycle -> no response, llbit=1, FSM back in HELD.
REQ-039 Scenario: ll_commit and CSR write 0x2 in the same cycle -> llbit=0.
REQ-040 Scenario with LLSC_ADDR_CHECK_EN: LL 0x1000; SC 0x1004 -> ok=0, llbit=0.

Source files
------------

// File: rtl/llbit_ctrl.sv
// LL/SC reservation controller: LLBit, LLBCTL.KLO and the SC success handshake.
// Define LLSC_ADDR_CHECK_EN to make SC success also require a word-address match with the last LL.
module llbit_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ll_commit,
  input  logic [31:0] ll_addr,
  input  logic        sc_req_valid,
  output logic        sc_req_ready,
  input  logic [31:0] sc_addr,
  output logic        sc_resp_valid,
  output logic        sc_resp_ok,
  input  logic        sc_resp_ready,
  input  logic        ertn,
  input  logic        flush,
  input  logic        llbctl_we,
  input  logic [31:0] llbctl_wdata,
  output logic [31:0] llbctl_rdata,
  output logic        llbit
);

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_SC_PEND} state_t;

  state_t r_state, w_state_nxt;
  logic   r_llbit, w_llbit_nxt;
  logic   r_klo, w_klo_nxt;
  logic   r_ok, w_ok_nxt;
  logic   w_accept, w_hs, w_set, w_clr, w_match;
  logic   w_unused_addr, w_unused_wdata;

  assign w_unused_wdata = ^{llbctl_wdata[31:3], llbctl_wdata[0]};

`ifdef LLSC_ADDR_CHECK_EN
  logic [29:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_addr <= '0;
    else if (w_set) r_addr <= ll_addr[31:2];
  end

  assign w_match       = (sc_addr[31:2] == r_addr);
  assign w_unused_addr = ^{ll_addr[1:0], sc_addr[1:0]};
`else
  assign w_match       = 1'b1;
  assign w_unused_addr = ^{ll_addr, sc_addr};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_llbit <= 1'b0;
      r_klo   <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_llbit <= w_llbit_nxt;
      r_klo   <= w_klo_nxt;
      r_ok    <= w_ok_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    sc_req_ready  = (r_state != ST_SC_PEND);
    sc_resp_valid = (r_state == ST_SC_PEND);
    // Flush dominates: it blocks new requests and swallows an outstanding response.
    w_accept      = sc_req_valid && sc_req_ready && !flush;
    w_hs          = sc_resp_valid && sc_resp_ready && !flush;
    w_set         = ll_commit && (r_state != ST_SC_PEND);
    // All clears agree in direction, so they combine; any clear beats a same-cycle LL set.
    w_clr         = (ertn && !r_klo) || (llbctl_we && llbctl_wdata[1]) || w_hs;
    w_llbit_nxt   = w_clr ? 1'b0 : (w_set ? 1'b1 : r_llbit);
    w_klo_nxt     = (ertn && r_klo) ? 1'b0 : (llbctl_we ? llbctl_wdata[2] : r_klo);
    w_ok_nxt      = w_accept ? (r_llbit && w_match) : r_ok;

    if (flush) begin
      w_state_nxt = w_llbit_nxt ? ST_HELD : ST_IDLE;
    end else begin
      case (r_state)
        ST_SC_PEND: if (w_hs) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = w_accept    ? ST_SC_PEND :
                                  w_llbit_nxt ? ST_HELD : ST_IDLE;
      endcase
    end
  end

  assign sc_resp_ok   = r_ok;
  assign llbit        = r_llbit;
  assign llbctl_rdata = {29'b0, r_klo, 1'b0, r_llbit};

endmodule
